// File: rtl/bka_pkg.sv
// Shared definitions for the sequential wide Brent-Kung adder.
//   WORD_W    : width of one adder-core word
//   state_t   : control FSM states (IDLE, RUN, DONE)
//   idx_width : width of the word index register, never below 1 bit
package bka_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned words);
    int unsigned w;
    w = (words > 1) ? int'($clog2(words)) : 1;
    return w;
  endfunction

endpackage

// File: rtl/add16_bk.sv
// Combinational 16-bit Brent-Kung prefix adder.
//   a, b : 16-bit addends
//   cin  : carry-in
//   sum  : 16-bit result
//   cout : carry-out of bit 15
module add16_bk (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] w_p;
  logic [15:0] w_gg;
  logic [15:0] w_gp;

  // Up-sweep builds power-of-two group terms, down-sweep fills the gaps.
  // cin is folded into bit 0 so every w_gg[i] is the carry out of bit i.
  always_comb begin
    w_p     = a ^ b;
    w_gg    = a & b;
    w_gp    = w_p;
    w_gg[0] = w_gg[0] | (w_p[0] & cin);
    for (int d = 1; d < 16; d = d * 2) begin
      for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_gp[i] & w_gg[i-d]);
        w_gp[i] = w_gp[i] & w_gp[i-d];
      end
    end
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_gp[i] & w_gg[i-d]);
        w_gp[i] = w_gp[i] & w_gp[i-d];
      end
    end
    sum  = w_p ^ {w_gg[14:0], cin};
    cout = w_gg[15];
  end

endmodule

// File: rtl/bka_seq_wide_adder.sv
// Multi-cycle wide adder: one 16-bit word per cycle through a single
// Brent-Kung core, LS word first, carry held in a register between words.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (accept only in IDLE)
//   a, b, cin            : operands (16*WORDS bits) and carry-in
//   out_valid / out_ready: result handshake (result held in DONE)
//   sum, cout            : result and carry-out of the top word
// Optional macro BKA_SEQ_SUB_EN adds port op_sub (a - b when set).
module bka_seq_wide_adder
  import bka_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*WORDS-1:0]  a,
  input  logic [WORD_W*WORDS-1:0]  b,
  input  logic                     cin,
`ifdef BKA_SEQ_SUB_EN
  input  logic                     op_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*WORDS-1:0]  sum,
  output logic                     cout
);

  localparam int unsigned W     = WORD_W * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_last;
  logic [31:0]      w_shamt;
  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_core_sum;
  logic             w_core_cout;
  logic [W-1:0]     w_word_mask;
  logic [W-1:0]     w_word_ins;
  logic [W-1:0]     w_b_in;
  logic             w_carry_in;

  // Operand conditioning at capture: subtract stores ~b and forces carry 1.
`ifdef BKA_SEQ_SUB_EN
  assign w_b_in     = op_sub ? ~b : b;
  assign w_carry_in = op_sub | cin;
`else
  assign w_b_in     = b;
  assign w_carry_in = cin;
`endif

  // Word select and write-back positioning for the current index.
  assign w_last      = (r_idx == LAST_IDX);
  assign w_shamt     = 32'(WORD_W) * 32'(r_idx);
  assign w_a_word    = WORD_W'(r_a >> w_shamt);
  assign w_b_word    = WORD_W'(r_b >> w_shamt);
  assign w_word_mask = W'({WORD_W{1'b1}}) << w_shamt;
  assign w_word_ins  = W'(w_core_sum) << w_shamt;

  add16_bk u_core (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_core_sum),
    .cout (w_core_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid)  w_next = RUN;
      RUN:  if (w_last)    w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_next == DONE);
      r_in_ready  <= (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_carry_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= (r_sum & ~w_word_mask) | w_word_ins;
          r_carry <= w_core_cout;
          if (w_last) begin
            r_cout <= w_core_cout;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_bka_seq_wide_adder.sv
// Bench for bka_seq_wide_adder: a WORDS=4 and a WORDS=1 instance share the
// clock and reset; sel1 steers the handshake to one of them at a time.
module tb_bka_seq_wide_adder;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic          cin;
  logic          op_sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sel1;

  logic          iv4, iv1;
  logic          in_ready4, in_ready1;
  logic          out_valid4, out_valid1;
  logic [W-1:0]  sum4;
  logic [15:0]   sum1;
  logic          cout4, cout1;

  logic          ov_m, ir_m, cout_m;
  logic [W-1:0]  sum_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign iv4    = in_valid & ~sel1;
  assign iv1    = in_valid & sel1;
  assign ov_m   = sel1 ? out_valid1 : out_valid4;
  assign ir_m   = sel1 ? in_ready1  : in_ready4;
  assign cout_m = sel1 ? cout1      : cout4;
  assign sum_m  = sel1 ? {48'h0, sum1} : sum4;

  bka_seq_wide_adder #(.WORDS(WORDS)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BKA_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .sum       (sum4),
    .cout      (cout4)
  );

  bka_seq_wide_adder #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (in_ready1),
    .a         (a[15:0]),
    .b         (b[15:0]),
    .cin       (cin),
`ifdef BKA_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand width, {cout, sum}.
  function automatic logic [W:0] model(input logic s1, input logic [W-1:0] aa,
                                       input logic [W-1:0] bb, input logic ci,
                                       input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bx;
    logic         cx;
    bx = sub ? ~bb : bb;
    cx = sub ? 1'b1 : ci;
    if (s1) begin
      full = (W+1)'(aa[15:0]) + (W+1)'(bx[15:0]) + (W+1)'(cx);
      return {full[16], 48'h0, full[15:0]};
    end
    full = (W+1)'(aa) + (W+1)'(bx) + (W+1)'(cx);
    return full;
  endfunction

  // One full transaction on the selected instance; returns {cout, sum}.
  task automatic do_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tci, input logic tsub, input int stall,
                        output logic [W:0] got);
    int n;
    logic [W-1:0] held;
    @(negedge clk);
    check({tag, " in_ready"}, 128'(ir_m), 128'(1'b1));
    a = ta; b = tb_v; cin = tci; op_sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom);
    n = 0;
    while (!ov_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(sel1 ? 1 : WORDS));
    got  = {cout_m, sum_m};
    held = sum_m;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, " stall hold"}, {ov_m, sum_m}, {1'b1, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " drained"}, 128'(ov_m), 128'(1'b0));
  endtask

  initial begin
    logic [W:0]   got;
    logic [W:0]   exp;
    logic [W-1:0] ra, rb, held;
    logic         rc, rs;
    int           n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; op_sub = 1'b0;
    a = '0; b = '0; sel1 = 1'b0;
    #12;
    check("reset out_valid", 128'(out_valid4), 128'(1'b0));
    check("reset in_ready",  128'(in_ready4),  128'(1'b1));
    check("reset sum/cout",  {cout4, sum4},    '0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post-reset in_ready", 128'(in_ready4), 128'(1'b1));

    // All-ones plus one wraps to zero with carry out.
    do_txn("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, got);
    check("wrap sum",  got[W-1:0], 128'(64'h0));
    check("wrap cout", 128'(got[W]), 128'(1'b1));

    // Carry crossing from word 0 into word 1.
    do_txn("carry01", 64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b0, 0, got);
    check("carry01 sum",  got[W-1:0], 128'(64'h0000_0000_0001_0001));
    check("carry01 cout", 128'(got[W]), 128'(1'b0));

    // DONE back-pressure with in_valid toggling new operands.
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin @(negedge clk); n++; end
    check("bp latency", 128'(n), 128'(WORDS));
    exp = model(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    check("bp result", {cout4, sum4}, 128'(exp));
    held = sum4;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(negedge clk);
      check("bp hold", {out_valid4, in_ready4, sum4}, {1'b1, 1'b0, held});
    end
    ra = 64'h0000_FFFF_0000_FFFF; rb = 64'h0000_0001_0000_0001; rc = 1'b0;
    a = ra; b = rb; cin = rc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release no accept", {out_valid4, in_ready4}, 128'(2'b01));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next accept", 128'(in_ready4), 128'(1'b0));
    n = 0;
    while (!out_valid4 && n < 20) begin @(negedge clk); n++; end
    check("bp2 latency", 128'(n), 128'(WORDS));
    check("bp2 result", {cout4, sum4}, 128'({1'b0, 64'h0001_0000_0001_0000}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while RUN is on word index 2.
    @(negedge clk);
    a = 64'h5555_5555_5555_5555; b = 64'h1111_1111_1111_1111; cin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset", {out_valid4, in_ready4, cout4, sum4}, {1'b0, 1'b1, 1'b0, 64'h0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WORDS + 2; k++) begin
      @(negedge clk);
      check("midrun no result", 128'(out_valid4), 128'(1'b0));
    end
    check("midrun in_ready", 128'(in_ready4), 128'(1'b1));

`ifdef BKA_SEQ_SUB_EN
    do_txn("sub5-7", 64'd5, 64'd7, 1'b1, 1'b1, 0, got);
    check("sub5-7 result", 128'(got), 128'({1'b0, 64'hFFFF_FFFF_FFFF_FFFE}));
    do_txn("sub7-5", 64'd7, 64'd5, 1'b1, 1'b1, 0, got);
    check("sub7-5 result", 128'(got), 128'({1'b1, 64'h2}));
`endif

    // Random vectors with random consumer stalls on both widths.
    for (int i = 0; i < 1000; i++) begin
      sel1 = (i >= 600);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 50 == 0) ra = '1;
      rc = 1'($urandom);
`ifdef BKA_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_txn("rnd", ra, rb, rc, rs, int'($urandom_range(0, 3)), got);
      exp = model(sel1, ra, rb, rc, rs);
      check("rnd result", 128'(got), 128'(exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bka_seq_wide_adder.md
Name: bka_seq_wide_adder

Overview:
Multi-cycle wide adder that drives a 16-bit Brent-Kung adder core and consumes its results. It adds two 16*WORDS-bit operands one 16-bit word per cycle, least-significant word first, carrying cout of each word into cin of the next. A valid/ready handshake on both sides lets it sit between an operand producer and a result consumer in the datapath.

Parameters:
WORDS, 4, number of 16-bit words per operand (>=1); total width W = 16*WORDS

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
a  in  W  operand A
b  in  W  operand B
cin  in  1  carry-in to word 0
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  W  result
cout  out  1  carry-out of the top word

Behaviour:
- Reset (async, rst_n=0): state IDLE, word index=0, carry reg=0, sum=0, cout=0, out_valid=0. in_ready is 1 while in reset and after release.
- FSM states are IDLE, RUN and DONE. in_ready = (state==IDLE). out_valid = (state==DONE), driven from a register.
- IDLE: on in_valid&&in_ready, register a, b and carry<=cin, set idx<=0, and go to RUN.
- RUN: each cycle the core adds a_r[idx], b_r[idx] and carry. Write the 16-bit result into sum[16*idx +: 16] and set carry<=core cout.
  - If idx==WORDS-1: cout<=core cout and go to DONE.
  - Otherwise: idx<=idx+1.
- DONE: sum and cout hold stable while out_ready=0. On out_ready=1, go to IDLE at that edge. No new accept happens in the same cycle.
- Latency: out_valid rises exactly WORDS clock edges after the accepting edge. Minimum initiation interval is WORDS+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). Carry ripples only between word iterations; there is no combinational path across words.
- Meaning of sum/cout:
  - They are meaningful only while out_valid=1.
  - During RUN the sum bus is partially updated.
  - The bench checks them only when out_valid=1.
- in_valid while RUN or DONE is ignored, and the operands are not captured.
- The input side needs no stable-data rule; a and b are sampled only on the accepting edge.
- WORDS=1: one RUN cycle, and out_valid comes 1 edge after accept. The idx register is at least 1 bit wide.
- Reset mid-operation (RUN or DONE): the operation is aborted and no result is ever presented. Outputs return to reset values immediately (async).
- Wrap-around: an all-ones operand plus 1 gives sum=0 and cout=1. This is not an error.

Optional Feature:
Macro BKA_SEQ_SUB_EN.
- Defined: the block adds input port op_sub (1 bit), sampled with the operands.
  - op_sub=1: the block computes a + ~b + 1, i.e. a-b. cin is ignored, and the carry reg is initialised to 1.
  - cout=1 means no borrow.
  - op_sub=0: identical to the base behaviour.
- Not defined: the op_sub port is absent and the block is add-only with cin. There is no extra logic.

Decomposition:
- Package bka_pkg holds:
  - WORD_W=16;
  - the state typedef (IDLE, RUN, DONE);
  - a helper function for the idx width, max(1,$clog2(WORDS)).
- One sub-module: add16_bk, a combinational 16-bit Brent-Kung prefix adder with ports a[15:0], b[15:0], cin, sum[15:0], cout. It is instantiated once; the word muxing and the carry register stay in the top module.

Test Plan:
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, out_valid high exactly 4 edges after accept.
- a=0x0000_0000_0000_FFFF, b=0x0000_0000_0000_0001, cin=1 -> sum=0x0000_0000_0001_0001, cout=0. This checks the carry crossing word 0->1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands:
  - out_valid stays 1, sum stays stable and in_ready stays 0;
  - after out_ready=1, the next accept is allowed only in the following cycle;
  - the ignored operands never appear.
- Assert rst_n=0 while in RUN with idx=2 -> out_valid=0 and sum=0 immediately; in_ready=1 after release; no result is emitted.
- 1000 random vectors with random out_ready stalls, builds WORDS=4 and WORDS=1 -> {cout,sum} matches the golden a+b+cin every time.
- BKA_SEQ_SUB_EN defined, op_sub=1, a=5, b=7, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. With a=7, b=5 -> sum=2, cout=1.
